// File: rtl/opram_pkg.sv
// Shared types and constants for the operand RAM controller.
package opram_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/opram_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module opram_rr_arb2
  import opram_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = (last == REQ_B);
        gnt_b = (last == REQ_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= REQ_A;
    end else if (gnt_a) begin
      last <= REQ_A;
    end else if (gnt_b) begin
      last <= REQ_B;
    end
  end

endmodule

// File: rtl/opram_ctrl.sv
// Operand RAM controller: zero-fill after reset/clear, then round-robin
// single-port access for two requesters with one-cycle read return.
//
//   state | meaning
//   FILL  | writing INIT_VAL to entry cnt, no grants, busy=1
//   RUN   | arbitrating requester A/B, one access per cycle
module opram_ctrl
  import opram_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  output logic          busy,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_ce,
  output logic          ram_wre,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          ce_c, wre_c;
  logic          arb_en;

  assign arb_en = (state == RUN) && !clear;

  opram_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req_a   (a_req),
    .req_b   (b_req),
    .gnt_a   (a_gnt),
    .gnt_b   (b_gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ce_c      = 1'b0;
    wre_c     = 1'b0;
    ram_ad    = '0;
    ram_din   = '0;
    case (state)
      FILL: begin
        ce_c    = 1'b1;
        wre_c   = 1'b1;
        ram_ad  = cnt;
        ram_din = INIT_VAL;
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == {AW{1'b1}}) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
        if (a_gnt) begin
          ce_c    = 1'b1;
          wre_c   = a_we;
          ram_ad  = a_addr;
          ram_din = a_wdata;
        end else if (b_gnt) begin
          ce_c    = 1'b1;
          wre_c   = b_we;
          ram_ad  = b_addr;
          ram_din = b_wdata;
        end
      end
    endcase
  end

  // Gate the enables with reset so the RAM sees no writes while held in reset.
  assign ram_ce    = ce_c & reset_n;
  assign ram_wre   = wre_c & reset_n;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign busy      = (state == FILL);
  assign rdata     = ram_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

endmodule

// File: doc/opram_ctrl.md
# opram_ctrl

Two-requester controller for the 8×8 operand RAM (`opram`, a single-port synchronous block RAM with one-cycle read latency). After reset, or on a `clear` pulse, it zero-fills all eight entries. It then arbitrates round-robin between requester A (host/loader) and requester B (execution core), issuing at most one RAM access per cycle. It sits between both requesters and the `opram` instance and owns every `opram` control pin.

## Interface
Parameters:
- `AW`, 3: RAM address width (8 entries).
- `DW`, 8: RAM data width.
- `INIT_VAL`, 8'h00: value written to every entry during fill.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  one-cycle pulse; restarts the fill sequence.
- `busy`  out  1  high while filling.
- `a_req`, `b_req`  in  1  access request, held until granted.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  AW  entry address.
- `a_wdata`, `b_wdata`  in  DW  write data.
- `a_gnt`, `b_gnt`  out  1  combinational; the access is performed this cycle.
- `a_rvalid`, `b_rvalid`  out  1  registered; read data is valid this cycle.
- `rdata`  out  DW  shared read data, equal to `ram_dout`.
- `ram_ce`, `ram_wre`, `ram_oce`, `ram_reset`  out  1  drive the `opram` pins of the same names.
- `ram_ad`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data.

## Operation
- States: FILL, RUN. Reset enters FILL with fill counter `cnt` = 0.
- FILL, every cycle:
  - Drive `ram_ce`=1, `ram_wre`=1, `ram_ad`=`cnt`, `ram_din`=`INIT_VAL`.
  - `cnt` increments; at `cnt`=7 the next state is RUN and `cnt` wraps to 0.
  - Both grants stay 0 and `busy`=1.
- RUN:
  - `busy`=0.
  - Arbitration: if only one requester has `req`=1, it is granted. If both do, the requester other than `last` is granted.
  - `last` updates to the granted requester. It is 1 bit, reset value A, so B wins the first tie.
  - Granted access drives `ram_ce`=1, `ram_wre`=`x_we`, `ram_ad`=`x_addr`, `ram_din`=`x_wdata`.
  - No grant: `ram_ce`=0, `ram_wre`=0, and `ram_ad`/`ram_din` hold 0.
- Handshake:
  - A transfer completes on a rising edge where `x_req`=1 and `x_gnt`=1.
  - Requesters keep `req`, `we`, `addr` and `wdata` stable until granted.
  - The controller never grants without `req`.
- Read return: a granted read sets `x_rvalid`=1 in the following cycle, with `rdata`=`ram_dout`. Writes never raise `rvalid`.
- `clear` in RUN:
  - Next cycle enters FILL with `cnt`=0.
  - Grants in the `clear` cycle are 0; `clear` wins over simultaneous requests.
  - An `rvalid` already owed from the previous cycle is still delivered.
- `clear` in FILL: restarts `cnt` at 0.
- Fixed pins: `ram_oce`=1 and `ram_reset`=0 at all times.
- Back-to-back accesses are allowed, one per cycle, with no bubble.
  - A write followed by a read of the same address returns the new data.
  - A read granted in cycle N while a write to the same address is granted in cycle N+1 returns the old data in N+1.

## Timing
- Reset values:
  - State FILL, `cnt`=0, `last`=A.
  - `busy`=1.
  - `a_rvalid`=`b_rvalid`=0 and `a_gnt`=`b_gnt`=0.
  - `ram_oce`=1 and `ram_reset`=0.
  - While `reset_n`=0: `ram_ce`=0 and `ram_wre`=0.
- Fill timing: after `reset_n` rises, FILL lasts exactly 8 cycles, writing addresses 0..7. The first grant is possible in cycle 8.
- Read latency: grant in cycle N gives `rvalid`/`rdata` in cycle N+1, one cycle.
- Grants are combinational from `req`, state, `clear` and `last`. There is no combinational path from `ram_dout` to any grant.
- Reset asserted mid-access aborts the access: `rvalid` is cleared immediately and fill restarts after release.

## Structure
- Package `opram_pkg`:
  - `AW`/`DW` defaults.
  - State enum {FILL, RUN}.
  - Requester id constants `REQ_A`=0, `REQ_B`=1.
- Sub-module `opram_rr_arb2`: two-input round-robin arbiter holding the `last` register, with an `en` input to suppress grants.
- The controller instantiates the arbiter and drives an external `opram` instance. It does not instantiate `opram` itself.

## Test plan
- Reset release with no requests: `ram_wre`=1 for 8 cycles at `ram_ad` 0..7 with `ram_din`=00 and `busy`=1, then `busy`=0; reads of all 8 entries return 00.
- A writes 3←8'h5A; next cycle B reads 3: `b_gnt`=1 that cycle, then `b_rvalid`=1 with `rdata`=5A one cycle later.
- `a_req` and `b_req` held continuously on reads: grants alternate B,A,B,A starting with B; each `rvalid` goes to the requester granted the previous cycle.
- Write 7←8'hC3, then pulse `clear` while both `req`s are high: no grant that cycle, 8 fill cycles follow, and a read of 7 returns 00.
- `reset_n` asserted in the cycle after a read grant: `rvalid` drops immediately; after release, fill restarts at address 0.
- Write to 2 in cycle N and read of 2 in cycle N+1: `rdata` shows the written value in N+2; idle cycles show `ram_ce`=0.
